// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one iic_master command port between N_REQ
// requesters. One complete single-register transaction is in flight at a
// time. The owner receives a one-cycle ack, plus err when the master never
// started. The owner also receives read data.
//
// Handshake: a requester holds req[i] high with stable fields until it sees
// ack[i]. Fields are captured once at grant. m_send_en is held high until
// m_send_busy is seen high, or until the start timeout expires. Completion
// is the first cycle m_send_busy is seen low after it was seen high.
//
// dbg_state encoding: 0 = IDLE, 1 = WAIT_START, 2 = WAIT_DONE.
module iic_arbiter #(
  parameter int N_REQ         = 3,
  parameter int REG_W         = 16,
  parameter int START_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*8-1:0]     req_slave_addr,
  input  logic [N_REQ-1:0]       req_rw,
  input  logic [N_REQ*REG_W-1:0] req_reg,
  input  logic [N_REQ*8-1:0]     req_wdata,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       err,
  output logic [7:0]             rdata,
  output logic [N_REQ-1:0]       grant,
  output logic [7:0]             m_slave_addr,
  output logic                   m_send_rw,
  output logic [REG_W-1:0]       m_reg_addr,
  output logic [7:0]             m_send_data,
  output logic                   m_send_en,
  input  logic [7:0]             m_recv_data,
  input  logic                   m_send_busy,
  output logic [1:0]             dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, owner_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [7:0]         sel_addr;
  logic               sel_rw;
  logic [REG_W-1:0]   sel_reg;
  logic [7:0]         sel_wdata;

  logic               do_grant, do_started, do_done, do_timeout;

  assign dbg_state = state_q;

  // Round-robin pick: first set req bit scanning upward from last_q+1, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pick_valid && req[i] &&
            ((int'(last_q) + k == i) || (int'(last_q) + k == i + N_REQ))) begin
          pick_valid = 1'b1;
          pick_idx   = IDX_W'(i);
          pick_oh[i] = 1'b1;
        end
      end
    end
  end

  // Mux the winning slot's transaction fields out of the packed buses.
  always_comb begin
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr  = req_slave_addr[8*i +: 8];
        sel_rw    = req_rw[i];
        sel_reg   = req_reg[REG_W*i +: REG_W];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // Next-state and transaction events; busy start beats the timeout.
  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_started = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stray master activity blocks new grants until the master is idle.
        if (pick_valid && !m_send_busy) begin
          do_grant = 1'b1;
          state_d  = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (m_send_busy) begin
          do_started = 1'b1;
          state_d    = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT)) begin
          do_timeout = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!m_send_busy) begin
          do_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Master command fields, grant/ack/err pulses, read data and rotation pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slave_addr <= '0;
      m_send_rw    <= 1'b0;
      m_reg_addr   <= '0;
      m_send_data  <= '0;
      m_send_en    <= 1'b0;
      ack          <= '0;
      err          <= '0;
      rdata        <= '0;
      grant        <= '0;
      owner_q      <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      cnt_q        <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      if (do_grant) begin
        m_slave_addr <= sel_addr;
        m_send_rw    <= sel_rw;
        m_reg_addr   <= sel_reg;
        m_send_data  <= sel_wdata;
        m_send_en    <= 1'b1;
        grant        <= pick_oh;
        owner_q      <= pick_idx;
        cnt_q        <= '0;
      end
      if (state_q == S_WAIT_START && !m_send_busy && !do_timeout) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (do_started) begin
        m_send_en <= 1'b0;
      end
      if (do_timeout || do_done) begin
        m_send_en <= 1'b0;
        ack       <= grant;
        err       <= do_timeout ? grant : '0;
        grant     <= '0;
        last_q    <= owner_q;
        if (do_done && m_send_rw) begin
          rdata <= m_recv_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// Bench for iic_arbiter: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_iic_arbiter;

  localparam int N    = 3;
  localparam int RW   = 16;
  localparam int TMO  = 15;
  localparam int AW   = N * 8;
  localparam int RGW  = N * RW;
  localparam int SB_W = 2 * N + 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [AW-1:0] req_slave_addr;
  logic [N-1:0]  req_rw;
  logic [RGW-1:0] req_reg;
  logic [AW-1:0] req_wdata;
  logic [N-1:0]  ack, err, grant;
  logic [7:0]    rdata, m_slave_addr, m_send_data, m_recv_data;
  logic          m_send_rw, m_send_en, m_send_busy;
  logic [RW-1:0] m_reg_addr;
  logic [1:0]    dbg_state;

  iic_arbiter #(.N_REQ(N), .REG_W(RW), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_slave_addr(req_slave_addr),
    .req_rw(req_rw), .req_reg(req_reg), .req_wdata(req_wdata),
    .ack(ack), .err(err), .rdata(rdata), .grant(grant),
    .m_slave_addr(m_slave_addr), .m_send_rw(m_send_rw), .m_reg_addr(m_reg_addr),
    .m_send_data(m_send_data), .m_send_en(m_send_en), .m_recv_data(m_recv_data),
    .m_send_busy(m_send_busy), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- master model ----------------
  int   mst_delay = 0;
  int   mst_len = 1;
  bit   mst_never = 1'b0;
  bit   mst_rand = 1'b0;
  logic [7:0] mst_rdata = 8'h00;

  initial begin
    int d, l;
    bit nv;
    logic [7:0] rd;
    m_send_busy = 1'b0;
    m_recv_data = 8'h00;
    forever begin
      @(posedge clk);
      if (m_send_en && !m_send_busy) begin
        if (mst_rand) begin
          d  = $urandom_range(0, 3);
          l  = $urandom_range(1, 6);
          nv = ($urandom_range(0, 9) == 0);
          rd = 8'($urandom);
        end else begin
          d = mst_delay; l = mst_len; nv = mst_never; rd = mst_rdata;
        end
        if (nv) begin
          while (m_send_en) @(posedge clk);
        end else begin
          repeat (d) @(posedge clk);
          #1 m_send_busy = 1'b1;
          m_recv_data = rd;
          repeat (l) @(posedge clk);
          #1 m_send_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  int mo_owner, mo_last, mo_cyc, mo_grant_cyc;
  bit mo_started;
  logic [N-1:0]  e_grant, e_ack, e_err;
  logic          e_en, e_rw;
  logic [7:0]    e_rdata, e_addr, e_wdata;
  logic [RW-1:0] e_reg;
  logic [SB_W-1:0] exp_q[$];

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mo_owner = -1; mo_last = N - 1; mo_started = 1'b0; mo_cyc = 0; mo_grant_cyc = 0;
    e_grant = '0; e_ack = '0; e_err = '0; e_en = 1'b0; e_rw = 1'b0;
    e_rdata = '0; e_addr = '0; e_wdata = '0; e_reg = '0;
    exp_q.delete();
  endtask

  task automatic model_finish(input bit timed_out);
    e_en  = 1'b0;
    e_ack = e_grant;
    e_err = timed_out ? e_grant : '0;
    if (!timed_out && e_rw) e_rdata = m_recv_data;
    exp_q.push_back({e_err, e_ack, e_rdata});
    mo_last  = mo_owner;
    mo_owner = -1;
    e_grant  = '0;
  endtask

  // Advances the model over the coming clock edge using the inputs that edge sees.
  task automatic model_step();
    bit found;
    int c;
    e_ack = '0;
    e_err = '0;
    if (rst) begin
      model_reset();
      return;
    end
    mo_cyc++;
    if (mo_owner < 0) begin
      if (req != '0 && !m_send_busy) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (mo_last + k) % N;
          if (!found && req[c]) begin
            found = 1'b1;
            mo_owner = c;
          end
        end
        e_grant = N'(1) << mo_owner;
        e_addr  = 8'(req_slave_addr >> (8 * mo_owner));
        e_rw    = req_rw[mo_owner];
        e_reg   = RW'(req_reg >> (RW * mo_owner));
        e_wdata = 8'(req_wdata >> (8 * mo_owner));
        e_en    = 1'b1;
        mo_started   = 1'b0;
        mo_grant_cyc = mo_cyc;
      end
    end else if (!mo_started) begin
      if (m_send_busy) begin
        mo_started = 1'b1;
        e_en = 1'b0;
      end else if (mo_cyc - mo_grant_cyc == TMO + 1) begin
        model_finish(1'b1);
      end
    end else if (!m_send_busy) begin
      model_finish(1'b0);
    end
  endtask

  // ---------------- compare ----------------
  task automatic compare();
    logic [SB_W-1:0] sb;
    logic [1:0] e_state;
    e_state = (mo_owner < 0) ? 2'd0 : (mo_started ? 2'd2 : 2'd1);
    chk("grant", 64'(grant), 64'(e_grant));
    chk("m_send_en", 64'(m_send_en), 64'(e_en));
    chk("ack", 64'(ack), 64'(e_ack));
    chk("err", 64'(err), 64'(e_err));
    chk("rdata", 64'(rdata), 64'(e_rdata));
    chk("m_slave_addr", 64'(m_slave_addr), 64'(e_addr));
    chk("m_send_rw", 64'(m_send_rw), 64'(e_rw));
    chk("m_reg_addr", 64'(m_reg_addr), 64'(e_reg));
    chk("m_send_data", 64'(m_send_data), 64'(e_wdata));
    chk("dbg_state", 64'(dbg_state), 64'(e_state));
    if (ack != '0) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("scoreboard", 64'({err, ack, rdata}), 64'(sb));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [7:0] a, input logic rw,
                          input logic [RW-1:0] r, input logic [7:0] d);
    req_slave_addr[s*8 +: 8] = a;
    req_rw[s]                = rw;
    req_reg[s*RW +: RW]      = r;
    req_wdata[s*8 +: 8]      = d;
  endtask

  task automatic wait_ack(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (ack != '0) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL ack_wait: no ack within %0d cycles at t=%0t", budget, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n, acks, cnt;
    bit ok, re;
    int ord[$];
    int exp_ord[4];
    logic [N-1:0] prev;
    exp_ord = '{0, 1, 2, 0};

    rst = 1'b1;
    req = '0; req_slave_addr = '0; req_rw = '0; req_reg = '0; req_wdata = '0;
    model_reset();
    @(negedge clk);
    compare();
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_en", 64'(m_send_en), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    tick();
    rst = 1'b0;

    // Single write on slot 1 with a 40-cycle busy master.
    mst_delay = 0; mst_len = 40;
    set_slot(1, 8'h78, 1'b0, 16'h3008, 8'h82);
    req = 3'b010;
    tick();
    chk("t1_grant", 64'(grant), 64'h2);
    chk("t1_slave", 64'(m_slave_addr), 64'h78);
    chk("t1_reg", 64'(m_reg_addr), 64'h3008);
    chk("t1_data", 64'(m_send_data), 64'h82);
    chk("t1_en", 64'(m_send_en), 64'h1);
    wait_ack(100, n, ok);
    chk("t1_latency", 64'(n), 64'd42);
    chk("t1_ack", 64'(ack), 64'h2);
    chk("t1_err", 64'(err), 64'h0);
    req = '0;
    tick();
    chk("t1_ack_single", 64'(ack), 64'h0);

    // Three simultaneous requesters; slot 0 re-requests during slot 1's turn.
    do_reset();
    mst_len = 3;
    set_slot(0, 8'h10, 1'b0, 16'h0001, 8'h01);
    set_slot(2, 8'h30, 1'b0, 16'h0003, 8'h03);
    req = 3'b111;
    acks = 0; re = 1'b0; prev = '0;
    for (int t = 0; t < 200 && acks < 4; t++) begin
      tick();
      if (grant != '0 && prev == '0) ord.push_back(oh_idx(grant));
      prev = grant;
      if (ack != '0) begin
        acks++;
        req = req & ~ack;
      end
      if (grant == 3'b010 && !re) begin
        req[0] = 1'b1;
        re = 1'b1;
      end
    end
    chk("t2_acks", 64'(acks), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", 64'((k < ord.size()) ? ord[k] : -1), 64'(exp_ord[k]));
    end
    tick();

    // Read on slot 2, then a write that must not disturb rdata.
    do_reset();
    mst_len = 1; mst_rdata = 8'h56;
    set_slot(2, 8'h3C, 1'b1, 16'h0102, 8'h00);
    req = 3'b100;
    tick();
    chk("t3_grant", 64'(grant), 64'h4);
    wait_ack(20, n, ok);
    chk("t3_latency", 64'(n), 64'd3);
    chk("t3_ack", 64'(ack), 64'h4);
    chk("t3_rdata", 64'(rdata), 64'h56);
    req = 3'b001;
    set_slot(0, 8'h20, 1'b0, 16'h0010, 8'h11);
    mst_rdata = 8'hA5;
    wait_ack(20, n, ok);
    chk("t3_wr_ack", 64'(ack), 64'h1);
    chk("t3_rdata_kept", 64'(rdata), 64'h56);
    req = '0;
    tick();

    // Start timeout: master never raises busy.
    mst_never = 1'b1;
    set_slot(1, 8'h42, 1'b0, 16'h0BAD, 8'h5A);
    req = 3'b010;
    tick();
    chk("t4_en_rise", 64'(m_send_en), 64'h1);
    wait_ack(40, n, ok);
    chk("t4_latency", 64'(n), 64'd16);
    chk("t4_ack", 64'(ack), 64'h2);
    chk("t4_err", 64'(err), 64'h2);
    chk("t4_en_low", 64'(m_send_en), 64'h0);
    req = '0;
    tick();
    mst_never = 1'b0;

    // Reset while the master is mid-transaction.
    mst_len = 40;
    set_slot(1, 8'h55, 1'b0, 16'h1234, 8'h66);
    req = 3'b010;
    tick();
    repeat (10) tick();
    rst = 1'b1;
    model_reset();
    #1;
    compare();
    chk("t5_rst_grant", 64'(grant), 64'h0);
    chk("t5_rst_en", 64'(m_send_en), 64'h0);
    chk("t5_rst_reg", 64'(m_reg_addr), 64'h0);
    set_slot(0, 8'h0E, 1'b0, 16'h00FE, 8'h77);
    req = 3'b001;
    tick();
    rst = 1'b0;
    mst_len = 2;
    ok = 1'b0; cnt = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      bit b;
      b = m_send_busy;
      tick();
      if (b) begin
        cnt++;
        chk("t5_no_grant_while_busy", 64'(grant), 64'h0);
      end
      if (grant != '0) ok = 1'b1;
    end
    chk("t5_busy_seen", 64'(cnt > 0), 64'h1);
    chk("t5_grant", 64'(grant), 64'h1);
    wait_ack(40, n, ok);
    chk("t5_ack", 64'(ack), 64'h1);
    chk("t5_err", 64'(err), 64'h0);
    req = '0;
    tick();

    // Requester drops req one cycle after grant; ack must still pulse once.
    mst_len = 5;
    set_slot(1, 8'h61, 1'b0, 16'h0042, 8'h24);
    req = 3'b010;
    tick();
    tick();
    req[1] = 1'b0;
    cnt = 0;
    repeat (30) begin
      tick();
      if (ack == 3'b010) cnt++;
    end
    chk("t6_ack_count", 64'(cnt), 64'd1);

    // Randomized traffic with a randomized master.
    mst_rand = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (req[i] && grant[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
      req_slave_addr = AW'($urandom);
      req_rw         = N'($urandom);
      req_reg        = RGW'({$urandom, $urandom});
      req_wdata      = AW'($urandom);
    end

    // Drain: no new requests, let outstanding ones finish.
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      tick();
      req = req & ~ack;
      if (req == '0 && grant == '0 && mo_owner < 0) ok = 1'b1;
    end
    chk("drain_idle", 64'(ok), 64'h1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
